// File: rtl/cm0_ahb_arb.sv
// rtl/cm0_ahb_arb.sv - two-master AHB-Lite arbiter with per-master address-phase buffers
//
// Ports:
//   hclk, hreset_n              clock, synchronous active-low reset
//   m0_* / m1_*                 upstream master ports (address/control/wdata in,
//                               hrdata/hready/hresp out)
//   haddr..hwdata               shared downstream AHB-Lite master port
//   hrdata, hready, hresp       shared downstream response
//   hmaster                     owner of the address phase currently driven
// ARB_MODE: 0 = round-robin, 1 = fixed priority (master 0 highest).
module cm0_ahb_arb #(
  parameter int ARB_MODE = 0
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [3:0]  m0_hprot,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hready,
  output logic        m0_hresp,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [3:0]  m1_hprot,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hready,
  output logic        m1_hresp,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        hmaster
);

  // Address-phase buffers for a master that lost arbitration.
  logic        pend0, pend1;
  logic [31:0] paddr0, paddr1;
  logic        pwrite0, pwrite1;
  logic [2:0]  psize0, psize1;
  logic [3:0]  pprot0, pprot1;

  // Data-phase tracking and round-robin history.
  logic        dvld;
  logic        down;
  logic        last_gnt;

  logic        req0, req1;
  logic        gnt_vld;
  logic        grant;
  logic        cap0, cap1;

  always_comb begin
    req0 = pend0 | (!pend0 & m0_htrans[1]);
    req1 = pend1 | (!pend1 & m1_htrans[1]);

    // Arbitration only happens when the bus accepts a new address phase.
    gnt_vld = hreset_n & hready & (req0 | req1);
    if (req0 && req1) begin
      grant = (ARB_MODE == 1) ? 1'b0 : ~last_gnt;
    end else begin
      grant = ~req0;
    end

    hmaster = gnt_vld & grant;
    htrans  = gnt_vld ? 2'b10 : 2'b00;

    if (hmaster) begin
      haddr  = pend1 ? paddr1  : m1_haddr;
      hwrite = pend1 ? pwrite1 : m1_hwrite;
      hsize  = pend1 ? psize1  : m1_hsize;
      hprot  = pend1 ? pprot1  : m1_hprot;
    end else begin
      haddr  = pend0 ? paddr0  : m0_haddr;
      hwrite = pend0 ? pwrite0 : m0_hwrite;
      hsize  = pend0 ? psize0  : m0_hsize;
      hprot  = pend0 ? pprot0  : m0_hprot;
    end

    // A master owning the data phase follows the bus; a buffered master is
    // stalled so it holds its address until the buffered transfer issues.
    if (!hreset_n) begin
      m0_hready = 1'b1;
      m1_hready = 1'b1;
      m0_hresp  = 1'b0;
      m1_hresp  = 1'b0;
    end else begin
      m0_hready = (dvld && !down) ? hready : !pend0;
      m1_hready = (dvld &&  down) ? hready : !pend1;
      m0_hresp  = dvld && !down && hresp;
      m1_hresp  = dvld &&  down && hresp;
    end

    m0_hrdata = hrdata;
    m1_hrdata = hrdata;
    hwdata    = (dvld && down) ? m1_hwdata : m0_hwdata;

    // The loser of this cycle's arbitration is buffered if it sees its
    // transfer accepted (hready high) and is not already buffered.
    cap0 = gnt_vld &  grant & !pend0 & m0_htrans[1] & m0_hready;
    cap1 = gnt_vld & !grant & !pend1 & m1_htrans[1] & m1_hready;
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      dvld     <= 1'b0;
      down     <= 1'b0;
      last_gnt <= 1'b1;
    end else if (hready) begin
      if (gnt_vld) begin
        last_gnt <= grant;
        dvld     <= 1'b1;
        down     <= grant;
        if (grant) begin
          pend1 <= 1'b0;
        end else begin
          pend0 <= 1'b0;
        end
      end else begin
        dvld <= 1'b0;
      end
      if (cap0) begin
        pend0 <= 1'b1;
      end
      if (cap1) begin
        pend1 <= 1'b1;
      end
    end
  end

  // Buffer payloads carry no reset; they are only meaningful while pendN is set.
  always_ff @(posedge hclk) begin
    if (cap0) begin
      paddr0  <= m0_haddr;
      pwrite0 <= m0_hwrite;
      psize0  <= m0_hsize;
      pprot0  <= m0_hprot;
    end
    if (cap1) begin
      paddr1  <= m1_haddr;
      pwrite1 <= m1_hwrite;
      psize1  <= m1_hsize;
      pprot1  <= m1_hprot;
    end
  end

endmodule

// File: tb/tb_cm0_ahb_arb.sv
// tb/tb_cm0_ahb_arb.sv - randomized model-checked bench for cm0_ahb_arb (both arbitration modes)
module tb_cm0_ahb_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset_n;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [31:0] hrdata;
  logic        hready, hresp;

  logic [31:0] o_m0_hrdata[2], o_m1_hrdata[2], o_haddr[2], o_hwdata[2];
  logic        o_m0_hready[2], o_m1_hready[2], o_m0_hresp[2], o_m1_hresp[2];
  logic [1:0]  o_htrans[2];
  logic        o_hwrite[2], o_hmaster[2];
  logic [2:0]  o_hsize[2];
  logic [3:0]  o_hprot[2];

  cm0_ahb_arb #(.ARB_MODE(0)) u_rr (
    .hclk(clk), .hreset_n(hreset_n),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata), .m0_hrdata(o_m0_hrdata[0]),
    .m0_hready(o_m0_hready[0]), .m0_hresp(o_m0_hresp[0]),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata), .m1_hrdata(o_m1_hrdata[0]),
    .m1_hready(o_m1_hready[0]), .m1_hresp(o_m1_hresp[0]),
    .haddr(o_haddr[0]), .htrans(o_htrans[0]), .hwrite(o_hwrite[0]), .hsize(o_hsize[0]),
    .hprot(o_hprot[0]), .hwdata(o_hwdata[0]), .hrdata(hrdata), .hready(hready),
    .hresp(hresp), .hmaster(o_hmaster[0])
  );

  cm0_ahb_arb #(.ARB_MODE(1)) u_fp (
    .hclk(clk), .hreset_n(hreset_n),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata), .m0_hrdata(o_m0_hrdata[1]),
    .m0_hready(o_m0_hready[1]), .m0_hresp(o_m0_hresp[1]),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata), .m1_hrdata(o_m1_hrdata[1]),
    .m1_hready(o_m1_hready[1]), .m1_hresp(o_m1_hresp[1]),
    .haddr(o_haddr[1]), .htrans(o_htrans[1]), .hwrite(o_hwrite[1]), .hsize(o_hsize[1]),
    .hprot(o_hprot[1]), .hwdata(o_hwdata[1]), .hrdata(hrdata), .hready(hready),
    .hresp(hresp), .hmaster(o_hmaster[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // Reference model, one copy per mode: who is waiting with what request,
  // who last won, and who owns the data phase.
  bit          waiting[2][2];
  logic [39:0] wbuf[2][2];
  int          last_win[2];
  bit          busy[2];
  int          owner[2];

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      waiting[md][0] = 0;
      waiting[md][1] = 0;
      busy[md]       = 0;
      owner[md]      = 0;
      last_win[md]   = 1;
    end
  endtask

  task automatic step();
    logic [39:0] live[2];
    bit          lreq[2];
    logic [31:0] wd[2];
    live[0] = {m0_hprot, m0_hsize, m0_hwrite, m0_haddr};
    live[1] = {m1_hprot, m1_hsize, m1_hwrite, m1_haddr};
    lreq[0] = m0_htrans[1];
    lreq[1] = m1_htrans[1];
    wd[0]   = m0_hwdata;
    wd[1]   = m1_hwdata;
    for (int md = 0; md < 2; md++) begin
      bit          want[2];
      int          win;
      bit          rdy[2];
      bit          rsp[2];
      logic [39:0] got;
      win = -1;
      for (int i = 0; i < 2; i++) want[i] = waiting[md][i] || lreq[i];
      if (hreset_n && hready) begin
        if (want[0] && want[1]) win = (md == 1) ? 0 : 1 - last_win[md];
        else if (want[0])       win = 0;
        else if (want[1])       win = 1;
      end
      for (int i = 0; i < 2; i++) begin
        if (!hreset_n)                     rdy[i] = 1;
        else if (busy[md] && owner[md] == i) rdy[i] = hready;
        else                               rdy[i] = !waiting[md][i];
        rsp[i] = hreset_n && busy[md] && owner[md] == i && hresp;
      end
      chk($sformatf("htrans[m%0d]", md), o_htrans[md], (win >= 0) ? 2 : 0);
      chk($sformatf("hmaster[m%0d]", md), o_hmaster[md], (win >= 0) ? win : 0);
      chk($sformatf("m0_hready[m%0d]", md), o_m0_hready[md], rdy[0]);
      chk($sformatf("m1_hready[m%0d]", md), o_m1_hready[md], rdy[1]);
      chk($sformatf("m0_hresp[m%0d]", md), o_m0_hresp[md], rsp[0]);
      chk($sformatf("m1_hresp[m%0d]", md), o_m1_hresp[md], rsp[1]);
      chk($sformatf("hrdata[m%0d]", md), {o_m1_hrdata[md], o_m0_hrdata[md]}, {hrdata, hrdata});
      if (hreset_n) begin
        chk($sformatf("hwdata[m%0d]", md), o_hwdata[md], busy[md] ? wd[owner[md]] : wd[0]);
        if (win >= 0) begin
          got = {o_hprot[md], o_hsize[md], o_hwrite[md], o_haddr[md]};
          chk($sformatf("addr_ctrl[m%0d]", md), got, waiting[md][win] ? wbuf[md][win] : live[win]);
        end
      end
      // advance model state for the coming clock edge
      if (!hreset_n) begin
        waiting[md][0] = 0;
        waiting[md][1] = 0;
        busy[md]       = 0;
        owner[md]      = 0;
        last_win[md]   = 1;
      end else if (hready) begin
        if (win >= 0) begin
          int lose;
          lose = 1 - win;
          if (!waiting[md][lose] && lreq[lose] && rdy[lose]) begin
            waiting[md][lose] = 1;
            wbuf[md][lose]    = live[lose];
          end
          waiting[md][win] = 0;
          last_win[md]     = win;
          busy[md]         = 1;
          owner[md]        = win;
        end else begin
          busy[md] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    m0_haddr  = $urandom;
    m1_haddr  = $urandom;
    m0_hwdata = $urandom;
    m1_hwdata = $urandom;
    m0_htrans = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 1));
    m1_htrans = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 1));
    m0_hwrite = 1'($urandom);
    m1_hwrite = 1'($urandom);
    m0_hsize  = 3'($urandom);
    m1_hsize  = 3'($urandom);
    m0_hprot  = 4'($urandom);
    m1_hprot  = 4'($urandom);
    hrdata    = $urandom;
    hready    = $urandom_range(0, 3) != 0;
    hresp     = $urandom_range(0, 6) == 0;
    hreset_n  = $urandom_range(0, 99) != 0;
  endtask

  logic [31:0] saved_addr;

  initial begin
    model_reset();
    randomize_inputs();
    hreset_n  = 1'b0;
    hready    = 1'b1;
    hresp     = 1'b0;
    m0_htrans = 2'b10;
    m1_htrans = 2'b10;

    // Two reset cycles with both masters requesting.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_htrans", o_htrans[0], 2'b00);
      chk("rst_m0_hready", o_m0_hready[0], 1'b1);
      chk("rst_m1_hready", o_m1_hready[0], 1'b1);
      tick();
    end

    // First cycle after reset: both NONSEQ, master 0 wins the tie.
    hreset_n = 1'b1;
    #1;
    chk("first_hmaster", o_hmaster[0], 1'b0);
    chk("first_haddr", o_haddr[0], m0_haddr);
    saved_addr = m1_haddr;
    tick();

    // Buffered master 1 transfer issues while master 1 is held off.
    m0_htrans = 2'b00;
    m1_haddr  = ~saved_addr;
    #1;
    chk("buf_haddr", o_haddr[0], saved_addr);
    chk("buf_hmaster", o_hmaster[0], 1'b1);
    chk("buf_m1_hready", o_m1_hready[0], 1'b0);
    tick();
    m1_htrans = 2'b00;
    #1;
    chk("dp_m1_hready", o_m1_hready[0], 1'b1);
    tick();

    // Reset while master 1 has a buffered transfer discards it.
    m0_htrans = 2'b10;
    m1_htrans = 2'b10;
    tick();
    hreset_n  = 1'b0;
    m0_htrans = 2'b00;
    m1_htrans = 2'b00;
    tick();
    hreset_n = 1'b1;
    #1;
    chk("rst_pend_m1_hready", o_m1_hready[0], 1'b1);
    chk("rst_pend_htrans", o_htrans[0], 2'b00);
    tick();

    for (int c = 0; c < 4000; c++) begin
      randomize_inputs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
